instruction_loader: RTL

Serial program loader that fills the instruction cache before the core runs; it is the writer side of the instruction-fetch path that PC and InstructionCache read.
- Accepts a byte stream over a valid/ready handshake: a 16-bit word count, then the payload.
- Assembles little-endian 32-bit instruction words and issues single-cycle writes to the instruction memory write port.
- Holds the core in reset-like stall (cpuHold) until the load completes.

---
 rtl/instruction_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// Serial program loader: takes a count-prefixed byte stream and writes little-endian
// 32-bit words to instruction memory, stalling the core until done. Optional: INSTRUCTION_LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        memWriteFlag,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        loadDone,
  output logic        loadError,
  output logic        cpuHold
);

  // state    | meaning
  // IDLE     | waiting for start after reset
  // COUNT_LO | accepting word-count low byte
  // COUNT_HI | accepting word-count high byte, range check
  // DATA     | accepting payload bytes into lanes 0..3
  // WRITE    | one-cycle memory write strobe
  // CHECK    | accepting checksum byte (checksum build only)
  // DONE     | load complete, core released
  // ERROR    | load aborted, core held
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COUNT_LO = 3'd1;
  localparam logic [2:0] S_COUNT_HI = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK    = 3'd5;
  localparam logic [2:0] S_TAIL     = S_CHECK;
`else
  localparam logic [2:0] S_TAIL     = 3'd6;
`endif
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERROR    = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] word_q, word_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [15:0] count_full;
  logic        xfer;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  always_comb begin
    byteReady = (state_q == S_COUNT_LO) || (state_q == S_COUNT_HI) || (state_q == S_DATA)
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                || (state_q == S_CHECK)
`endif
                ;
  end

  assign xfer         = byteValid && byteReady;
  assign count_full   = {byteIn, count_q[7:0]};
  assign memWriteFlag = (state_q == S_WRITE);
  assign memAddress   = mem_addr_q;
  assign memWriteData = mem_data_q;
  assign loadDone     = (state_q == S_DONE);
  assign loadError    = (state_q == S_ERROR);
  assign cpuHold      = (state_q != S_DONE);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_COUNT_LO;
          word_idx_d = 16'd0;
          byte_idx_d = 2'd0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
          chk_d      = 8'd0;
`endif
        end
      end
      S_COUNT_LO: begin
        if (xfer) begin
          count_d[7:0] = byteIn;
          state_d      = S_COUNT_HI;
        end
      end
      S_COUNT_HI: begin
        if (xfer) begin
          count_d = count_full;
          if ({16'd0, count_full} > MAX_WORDS) state_d = S_ERROR;
          else if (count_full == 16'd0)        state_d = S_TAIL;
          else                                 state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_d[7:0]   = byteIn;
            2'd1: word_d[15:8]  = byteIn;
            2'd2: word_d[23:16] = byteIn;
            default: begin
              // word is captured at the accepting edge so the strobe cycle sees it
              mem_data_d = {byteIn, word_q};
              mem_addr_d = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
              state_d    = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_q + 16'd1 == count_q) state_d = S_TAIL;
        else                               state_d = S_DATA;
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) state_d = (byteIn == chk_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    if (xfer && (state_q != S_CHECK)) chk_d = chk_q ^ byteIn;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= 16'd0;
      word_idx_q <= 16'd0;
      byte_idx_q <= 2'd0;
      word_q     <= 24'd0;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= 32'd0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      chk_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

endmodule
